// File: rtl/mux_8x1.sv
// Registered 8-to-1 lane multiplexer with a valid qualifier.
// Selected lane and valid appear one clock after sampling; y holds when idle.
module mux_8x1 #(
    parameter int DATA_W = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [8*DATA_W-1:0]   i,
    input  logic [2:0]            sel,
    input  logic                  in_valid,
    output logic [DATA_W-1:0]     y,
    output logic                  y_valid
);

    logic [DATA_W-1:0] lanes [8];

    // Lane k occupies i[k*DATA_W +: DATA_W]; lane 0 sits at the LSBs.
    always_comb begin
        for (int k = 0; k < 8; k++) begin
            lanes[k] = i[k*DATA_W +: DATA_W];
        end
    end

    // NOTE: registered state uses non-blocking assignments so every flop
    // samples pre-edge values and simulation matches the synthesized netlist.
    always_ff @(posedge clk) begin
        if (rst) begin
            y       <= '0;
            y_valid <= 1'b0;
        end else begin
            y_valid <= in_valid;
            if (in_valid) begin
                y <= lanes[sel];
            end
        end
    end

endmodule

// File: tb/tb_mux_8x1.sv
// Scoreboard bench for mux_8x1: a 1-bit instance and an 8-bit-lane instance.
// Stimulus pushes expected results; a monitor pops and compares one cycle later.
module tb_mux_8x1;

    typedef struct {
        logic       v;
        logic [7:0] y;
        string      tag;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst1, rst8;
    logic [7:0]  i1;
    logic [63:0] i8;
    logic [2:0]  sel1, sel8;
    logic        iv1, iv8;
    logic [0:0]  y1;
    logic [7:0]  y8;
    logic        yv1, yv8;

    exp_t q1[$];
    exp_t q8[$];
    logic       held1 = 1'b0;
    logic [7:0] held8 = 8'h00;
    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    mux_8x1 #(.DATA_W(1)) dut1 (
        .clk(clk), .rst(rst1), .i(i1), .sel(sel1), .in_valid(iv1),
        .y(y1), .y_valid(yv1)
    );

    mux_8x1 #(.DATA_W(8)) dut8 (
        .clk(clk), .rst(rst8), .i(i8), .sel(sel8), .in_valid(iv8),
        .y(y8), .y_valid(yv8)
    );

    task automatic check(input string tag, input logic got_v, input logic [7:0] got_y,
                         input logic want_v, input logic [7:0] want_y);
        total++;
        if (got_v !== want_v || got_y !== want_y) begin
            bad++;
            $display("FAIL %s: got y=%0h y_valid=%0b, want y=%0h y_valid=%0b",
                     tag, got_y, got_v, want_y, want_v);
        end
    endtask

    // Drive one cycle of the 1-bit instance and record what it must show next.
    task automatic step1(input string tag, input logic r, input logic v,
                         input logic [7:0] d, input logic [2:0] s);
        exp_t e;
        @(negedge clk);
        rst1 = r; iv1 = v; i1 = d; sel1 = s;
        if (r) begin
            held1 = 1'b0; e.v = 1'b0;
        end else if (v) begin
            held1 = d[s]; e.v = 1'b1;
        end else begin
            e.v = 1'b0;
        end
        e.y = {7'b0, held1};
        e.tag = tag;
        q1.push_back(e);
    endtask

    task automatic step8(input string tag, input logic r, input logic v,
                         input logic [63:0] d, input logic [2:0] s);
        exp_t e;
        @(negedge clk);
        rst8 = r; iv8 = v; i8 = d; sel8 = s;
        if (r) begin
            held8 = 8'h00; e.v = 1'b0;
        end else if (v) begin
            held8 = d[s*8 +: 8]; e.v = 1'b1;
        end else begin
            e.v = 1'b0;
        end
        e.y = held8;
        e.tag = tag;
        q8.push_back(e);
    endtask

    // Monitor: one expectation per captured edge, sampled just after the edge.
    always @(posedge clk) begin
        exp_t e;
        #1;
        if (q1.size() > 0) begin
            e = q1.pop_front();
            check(e.tag, yv1, {7'b0, y1}, e.v, e.y);
        end
        if (q8.size() > 0) begin
            e = q8.pop_front();
            check(e.tag, yv8, y8, e.v, e.y);
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, want completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [63:0] wide;
        rst1 = 1'b1; iv1 = 1'b0; i1 = '0; sel1 = '0;
        rst8 = 1'b1; iv8 = 1'b0; i8 = '0; sel8 = '0;
        repeat (2) @(negedge clk);

        // Reset dominates in_valid, then the first free edge captures lane 0.
        step1("reset_hold", 1'b1, 1'b1, 8'hFF, 3'd0);
        step1("reset_hold", 1'b1, 1'b1, 8'hFF, 3'd0);
        step1("reset_release", 1'b0, 1'b1, 8'hFF, 3'd0);

        for (int d = 0; d < 256; d++) begin
            for (int s = 0; s < 8; s++) begin
                step1("exhaustive", 1'b0, 1'b1, 8'(d), 3'(s));
            end
        end

        for (int k = 0; k < 8; k++) step1("walk_hit", 1'b0, 1'b1, 8'(1 << k), 3'(k));
        for (int k = 0; k < 8; k++) step1("walk_miss", 1'b0, 1'b1, 8'(1 << k), 3'((k + 1) % 8));

        step1("unknown_lanes", 1'b0, 1'b1, 8'bxxxx_xxx1, 3'd0);
        step1("unknown_lanes", 1'b0, 1'b1, 8'b1xxx_xxxx, 3'd7);

        step1("hold_capture", 1'b0, 1'b1, 8'h80, 3'd7);
        step1("hold_idle", 1'b0, 1'b0, 8'h00, 3'd7);
        step1("hold_idle", 1'b0, 1'b0, 8'h00, 3'd0);
        step1("hold_idle", 1'b0, 1'b0, 8'hFF, 3'd3);
        step1("hold_next", 1'b0, 1'b1, 8'h00, 3'd7);

        step1("stream", 1'b0, 1'b1, 8'h0F, 3'd1);
        step1("stream", 1'b0, 1'b1, 8'h0F, 3'd2);
        step1("mid_reset", 1'b1, 1'b1, 8'hFF, 3'd5);
        step1("resume", 1'b0, 1'b1, 8'h20, 3'd5);
        step1("resume", 1'b0, 1'b1, 8'h20, 3'd4);
        step1("resume_idle", 1'b0, 1'b0, 8'h00, 3'd0);

        // Wide lanes: lane k = 8'hA0 + k.
        for (int k = 0; k < 8; k++) wide[k*8 +: 8] = 8'hA0 + 8'(k);
        step8("wide_reset", 1'b1, 1'b1, wide, 3'd3);
        for (int k = 0; k < 8; k++) step8("wide_lane", 1'b0, 1'b1, wide, 3'(k));
        step8("wide_idle", 1'b0, 1'b0, 64'h0, 3'd0);
        step8("wide_lane", 1'b0, 1'b1, wide, 3'd7);
        step8("wide_reset_mid", 1'b1, 1'b1, wide, 3'd2);
        step8("wide_resume", 1'b0, 1'b1, wide, 3'd2);
        step8("wide_idle", 1'b0, 1'b0, 64'h0, 3'd0);

        repeat (3) @(negedge clk);
        check("drain_q1", 1'b0, 8'(q1.size()), 1'b0, 8'd0);
        check("drain_q8", 1'b0, 8'(q8.size()), 1'b0, 8'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
